// File: rtl/calc_entry_fsm.sv
// Keypad entry sequencer: assembles two 2-digit operands and an operator for the math block.
// Optional idle auto-clear is built only when ENTRY_TIMEOUT_EN is defined.
module calc_entry_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [4:0] num000,
    output logic [4:0] num001,
    output logic [4:0] num011,
    output logic [4:0] num100,
    output logic [2:0] num_state,
    output logic [4:0] arithmetic,
    output logic       enable,
    output logic       err
);

    typedef enum logic [2:0] {
        OPND1  = 3'b000,
        OPWAIT = 3'b001,
        OPND2  = 3'b010,
        RESULT = 3'b011,
        ERROR  = 3'b100
    } state_t;

    state_t     state_r;
    logic [1:0] cnt1_r;
    logic [1:0] cnt2_r;
    logic [4:0] tens1_r;
    logic [4:0] ones1_r;
    logic [4:0] tens2_r;
    logic [4:0] ones2_r;
    logic [4:0] arith_r;
    logic       enable_r;
    logic       err_r;

    logic       is_digit_s;
    logic       is_op_s;
    logic       is_eq_s;
    logic       clear_s;
    logic       timeout_s;

    // Key classification; codes 16..31 fall into no class and are ignored.
    always_comb begin
        is_digit_s = key_valid && (key_code <= 5'd9);
        is_op_s    = key_valid && (key_code >= 5'd11) && (key_code <= 5'd14);
        is_eq_s    = key_valid && (key_code == 5'd15);
        clear_s    = (key_valid && (key_code == 5'd10)) || timeout_s;
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IDLE_W-1:0] idle_r;
    logic              empty_s;

    assign empty_s   = (state_r == OPND1) && (cnt1_r == 2'd0) && (cnt2_r == 2'd0) && (arith_r == 5'd0);
    assign timeout_s = !key_valid && (idle_r == IDLE_W'(TIMEOUT_CYCLES - 32'd1));

    // Idle counter: runs only while a partial entry is pending and no key arrives.
    always_ff @(posedge clk) begin
        if (!reset_n || key_valid || timeout_s || empty_s) begin
            idle_r <= '0;
        end else begin
            idle_r <= idle_r + IDLE_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Entry FSM with registered digit, operator and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n || clear_s) begin
            state_r  <= OPND1;
            cnt1_r   <= 2'd0;
            cnt2_r   <= 2'd0;
            tens1_r  <= 5'd0;
            ones1_r  <= 5'd0;
            tens2_r  <= 5'd0;
            ones2_r  <= 5'd0;
            arith_r  <= 5'd0;
            enable_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (key_valid) begin
            case (state_r)
                OPND1: begin
                    if (is_digit_s) begin
                        if (cnt1_r == 2'd0) begin
                            tens1_r <= 5'd0;
                            ones1_r <= key_code;
                            cnt1_r  <= 2'd1;
                        end else if (cnt1_r == 2'd1) begin
                            tens1_r <= ones1_r;
                            ones1_r <= key_code;
                            cnt1_r  <= 2'd2;
                        end
                    end else if (is_op_s) begin
                        arith_r <= key_code;
                        state_r <= OPWAIT;
                    end
                end
                OPWAIT: begin
                    if (is_digit_s) begin
                        tens2_r <= 5'd0;
                        ones2_r <= key_code;
                        cnt2_r  <= 2'd1;
                        state_r <= OPND2;
                    end else if (is_op_s) begin
                        arith_r <= key_code;
                    end
                end
                OPND2: begin
                    if (is_digit_s) begin
                        if (cnt2_r == 2'd1) begin
                            tens2_r <= ones2_r;
                            ones2_r <= key_code;
                            cnt2_r  <= 2'd2;
                        end
                    end else if (is_eq_s) begin
                        // Divide by zero never reaches the math block.
                        if ((arith_r == 5'd14) && (tens2_r == 5'd0) && (ones2_r == 5'd0)) begin
                            state_r <= ERROR;
                            err_r   <= 1'b1;
                        end else begin
                            state_r  <= RESULT;
                            enable_r <= 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (is_digit_s) begin
                        tens1_r  <= 5'd0;
                        ones1_r  <= key_code;
                        cnt1_r   <= 2'd1;
                        tens2_r  <= 5'd0;
                        ones2_r  <= 5'd0;
                        cnt2_r   <= 2'd0;
                        arith_r  <= 5'd0;
                        state_r  <= OPND1;
                        enable_r <= 1'b0;
                    end
                end
                ERROR: begin
                    err_r <= 1'b1;
                end
                default: begin
                    state_r  <= OPND1;
                    enable_r <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    assign num000     = tens1_r;
    assign num001     = ones1_r;
    assign num011     = tens2_r;
    assign num100     = ones2_r;
    assign num_state  = state_r;
    assign arithmetic = arith_r;
    assign enable     = enable_r;
    assign err        = err_r;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Randomised bench for calc_entry_fsm against a queue-based model of the keypad rules.
// Honours ENTRY_TIMEOUT_EN (TIMEOUT_CYCLES = 8) when the macro is defined.
module tb_calc_entry_fsm;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = 5'd0;
    logic [4:0] num000, num001, num011, num100, arithmetic;
    logic [2:0] num_state;
    logic       enable, err;

    int checks = 0;
    int failures = 0;

    // Model: operands as digit queues, phase 0..4 = OPND1,OPWAIT,OPND2,RESULT,ERROR.
    int m_a[$];
    int m_b[$];
    int m_op = 0;
    int m_ph = 0;
    int m_idle = 0;

    calc_entry_fsm #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .num000(num000), .num001(num001), .num011(num011), .num100(num100),
        .num_state(num_state), .arithmetic(arithmetic), .enable(enable), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tens_of(input int q[$]);
        return (q.size() == 2) ? q[0] : 0;
    endfunction

    function automatic int ones_of(input int q[$]);
        return (q.size() == 0) ? 0 : q[q.size()-1];
    endfunction

    task automatic m_clear();
        m_a.delete();
        m_b.delete();
        m_op = 0;
        m_ph = 0;
        m_idle = 0;
    endtask

    task automatic m_key(input int c);
        bit dig, opk, eq;
        dig = (c < 10);
        opk = (c >= 11) && (c <= 14);
        eq  = (c == 15);
        if (c == 10) begin
            m_clear();
        end else if (c <= 15) begin
            case (m_ph)
                0: if (dig && m_a.size() < 2) m_a.push_back(c);
                   else if (opk) begin m_op = c; m_ph = 1; end
                1: if (dig) begin m_b.delete(); m_b.push_back(c); m_ph = 2; end
                   else if (opk) m_op = c;
                2: if (dig && m_b.size() < 2) m_b.push_back(c);
                   else if (eq) m_ph = (m_op == 14 && tens_of(m_b) * 10 + ones_of(m_b) == 0) ? 4 : 3;
                3: if (dig) begin m_clear(); m_a.push_back(c); end
                default: ;
            endcase
        end
    endtask

    task automatic m_edge(input bit rn, input bit v, input int c);
        bit idle_empty;
        if (!rn) begin
            m_clear();
        end else if (v) begin
            m_idle = 0;
            m_key(c);
        end else begin
`ifdef ENTRY_TIMEOUT_EN
            idle_empty = (m_ph == 0) && (m_a.size() == 0) && (m_op == 0);
            if (m_idle == TO - 1) m_clear();
            else if (!idle_empty) m_idle++;
            else m_idle = 0;
`else
            idle_empty = 1'b0;
`endif
        end
    endtask

    task automatic compare_all();
        check_eq("num000", int'(num000), tens_of(m_a));
        check_eq("num001", int'(num001), ones_of(m_a));
        check_eq("num011", int'(num011), tens_of(m_b));
        check_eq("num100", int'(num100), ones_of(m_b));
        check_eq("num_state", int'(num_state), m_ph);
        check_eq("arithmetic", int'(arithmetic), m_op);
        check_eq("enable", int'(enable), (m_ph == 3) ? 1 : 0);
        check_eq("err", int'(err), (m_ph == 4) ? 1 : 0);
    endtask

    task automatic step(input bit rn, input bit v, input int c);
        reset_n   = rn;
        key_valid = v;
        key_code  = 5'(c);
        @(posedge clk);
        m_edge(rn, v, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic keys(input int seq[$]);
        foreach (seq[i]) step(1'b1, 1'b1, seq[i]);
    endtask

    initial begin
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        check_eq("reset_state", int'(num_state), 0);

        // Entry and add
        keys('{4, 2, 11, 1, 7, 15});
        check_eq("add_num000", int'(num000), 4);
        check_eq("add_num100", int'(num100), 7);
        check_eq("add_arith", int'(arithmetic), 11);
        check_eq("add_state", int'(num_state), 3);
        check_eq("add_enable", int'(enable), 1);

        // Digit saturation
        keys('{10, 1, 2, 3});
        check_eq("sat_num000", int'(num000), 1);
        check_eq("sat_num001", int'(num001), 2);

        // Divide by zero, ignored keys, clear
        keys('{10, 9, 14, 0, 15});
        check_eq("dz_state", int'(num_state), 4);
        check_eq("dz_err", int'(err), 1);
        keys('{5, 15, 20, 10});
        check_eq("dz_clear_state", int'(num_state), 0);
        check_eq("dz_clear_err", int'(err), 0);

        // Operator replace, then restart from RESULT
        keys('{6, 11, 13, 3, 15});
        check_eq("rep_arith", int'(arithmetic), 13);
        keys('{8});
        check_eq("restart_num001", int'(num001), 8);
        check_eq("restart_arith", int'(arithmetic), 0);
        check_eq("restart_enable", int'(enable), 0);

        // Reset wins over a simultaneous key
        keys('{7, 12});
        step(1'b0, 1'b1, 5);
        check_eq("rst_prio_num001", int'(num001), 0);

        // Back-to-back plus idle gaps; ignored codes mid-entry
        keys('{3, 25, 4, 14, 16, 2, 31, 15});

`ifdef ENTRY_TIMEOUT_EN
        keys('{10, 3});
        for (int i = 0; i < TO - 1; i++) step(1'b1, 1'b0, 0);
        check_eq("to_before", int'(num001), 3);
        step(1'b1, 1'b0, 0);
        check_eq("to_fired", int'(num001), 0);
        for (int i = 0; i < 2 * TO; i++) step(1'b1, 1'b0, 0);
        check_eq("to_idle_state", int'(num_state), 0);
`endif

        // Randomised run
        for (int n = 0; n < 3000; n++) begin
            int c;
            c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 15);
            if ($urandom_range(0, 40) == 0) c = 10;
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
